// File: rtl/timer_pkg.sv
// Shared types and defaults for the down_timer block.
package timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_t;

endpackage

// File: rtl/reg_en_ar.sv
// Parameterised-width register with load enable and asynchronous active-high clear.
module reg_en_ar #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable synchronous down-counter with registered terminal-count pulse and optional
// auto-reload from the last loaded value.
module down_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] count_q, count_d, reload_q;
  logic             count_en, reload_en;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    count_en  = 1'b0;
    reload_en = 1'b0;
    tc_d      = 1'b0;
    if (load) begin
      count_d   = load_val;
      count_en  = 1'b1;
      reload_en = 1'b1;
      state_d   = (load_val != '0) ? StRun : StIdle;
    end else if (state_q == StRun && en) begin
      count_en = 1'b1;
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = StIdle;
        end
      end else begin
        // Zero while running is unreachable; park safely without wrapping.
        count_d = '0;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
    end
  end

  reg_en_ar #(
    .WIDTH(WIDTH)
  ) u_count (
    .clk(clk),
    .rst(rst),
    .en (count_en),
    .d  (count_d),
    .q  (count_q)
  );

  reg_en_ar #(
    .WIDTH(WIDTH)
  ) u_reload (
    .clk(clk),
    .rst(rst),
    .en (reload_en),
    .d  (load_val),
    .q  (reload_q)
  );

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == StRun);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: behavioural model compared every cycle plus
// directed literal expectations.
module tb_down_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Model state kept as plain integers so any wrap-around in the DUT shows up.
  int m_count  = 0;
  int m_reload = 0;
  int m_run    = 0;
  int m_tc     = 0;

  down_timer #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0; m_reload = 0; m_run = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (load) begin
        m_count  = int'(load_val);
        m_reload = int'(load_val);
        m_run    = (load_val != 0) ? 1 : 0;
      end else if (m_run == 1 && en) begin
        if (m_count == 1) begin
          m_tc = 1;
          if (auto_reload) m_count = m_reload;
          else begin
            m_count = 0;
            m_run   = 0;
          end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_count", int'(count), m_count);
      check("model_tc", int'(tc), m_tc);
      check("model_busy", int'(busy), m_run);
    end
  end

  task automatic cyc(input logic l, input int lv, input logic e, input logic ar);
    load        = l;
    load_val    = lv[W-1:0];
    en          = e;
    auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input int c, input int t, input int b);
    check({name, "_count"}, int'(count), c);
    check({name, "_tc"}, int'(tc), t);
    check({name, "_busy"}, int'(busy), b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int exp3[12] = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 4};
    int tc_hits;
    int tc_idx[$];

    #2 rst = 1'b1;
    #1 expect3("por", 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    // Asynchronous reset mid-count
    cyc(1'b1, 6, 1'b1, 1'b0);
    expect3("rst_load", 6, 0, 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    expect3("rst_run", 5, 0, 1);
    #3 rst = 1'b1;
    #1 expect3("rst_async", 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    expect3("rst_idle", 0, 0, 0);

    // One-shot
    cyc(1'b1, 3, 1'b1, 1'b0);
    expect3("os_load", 3, 0, 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    expect3("os_2", 2, 0, 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    expect3("os_1", 1, 0, 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    expect3("os_exp", 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b0);
      expect3("os_hold", 0, 0, 0);
    end

    // Auto-reload
    cyc(1'b1, 4, 1'b1, 1'b1);
    expect3("ar_load", 4, 0, 1);
    tc_hits = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b1);
      check("ar_count", int'(count), exp3[i]);
      if (tc) begin
        tc_hits++;
        tc_idx.push_back(i);
      end
    end
    check("ar_tc_hits", tc_hits, 3);
    if (tc_idx.size() == 3) begin
      check("ar_tc_gap1", tc_idx[1] - tc_idx[0], 4);
      check("ar_tc_gap2", tc_idx[2] - tc_idx[1], 4);
    end

    // Enable gaps; auto_reload low at the expiry edge ends the run
    cyc(1'b1, 2, 1'b1, 1'b1);
    expect3("gap_load", 2, 0, 1);
    cyc(1'b0, 0, 1'b1, 1'b1);
    expect3("gap_e1", 1, 0, 1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    expect3("gap_e0a", 1, 0, 1);
    cyc(1'b0, 0, 1'b0, 1'b1);
    expect3("gap_e0b", 1, 0, 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    expect3("gap_exp", 0, 1, 0);

    // Load collides with expiry
    cyc(1'b1, 2, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    expect3("col_pre", 1, 0, 1);
    cyc(1'b1, 9, 1'b1, 1'b0);
    expect3("col_load", 9, 0, 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    expect3("col_after", 8, 0, 1);

    // Zero load stays idle
    cyc(1'b1, 0, 1'b1, 1'b1);
    expect3("zero_load", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b1);
      expect3("zero_idle", 0, 0, 0);
    end

    // Max load
    cyc(1'b1, 15, 1'b1, 1'b0);
    expect3("max_load", 15, 0, 1);
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b0);
      check("max_count", int'(count), 15 - i);
      check("max_tc", int'(tc), (i == 15) ? 1 : 0);
    end
    cyc(1'b0, 0, 1'b1, 1'b0);
    expect3("max_after", 0, 0, 0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
